// File: rtl/sigmoid_stream_pwq.sv
// Multi-lane streaming sigmoid/tanh using the piecewise-quadratic core f(z) = z - z*|z|/4.
// Four-stage pipeline with a global stall, plus a saturating count of output beats that had a saturated lane.
module sigmoid_stream_pwq #(
  parameter int LANES = 16,
  parameter int XW    = 18,
  parameter int XFRAC = 14,
  parameter int YW    = 18,
  parameter int YFRAC = 16,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic                  in_last,
  input  logic [LANES*XW-1:0]   in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [LANES*YW-1:0]   out_y,
  input  logic                  cnt_clr,
  output logic [CNTW-1:0]       sat_cnt
);

  localparam int ZW  = XW + 1;
  localparam int PW  = 2 * ZW;
  localparam int SH  = XFRAC + 2;
  localparam int OSH = YFRAC - XFRAC;

  localparam logic signed [ZW-1:0] ONE     = ZW'(1 << XFRAC);
  localparam logic signed [ZW-1:0] HALF    = ZW'(1 << (XFRAC - 1));
  localparam logic signed [ZW-1:0] SAT_LIM = ZW'(2 << XFRAC);

  logic adv;
  logic v1, v2, v3;
  logic m1, m2, m3;
  logic l1, l2, l3;

  logic signed [XW-1:0] x_lane [LANES];
  logic signed [ZW-1:0] z_c    [LANES];
  logic signed [ZW-1:0] a_c    [LANES];
  logic [LANES-1:0]     sat_c;

  logic signed [ZW-1:0] s1_z   [LANES];
  logic signed [ZW-1:0] s1_a   [LANES];
  logic [LANES-1:0]     s1_sat;

  logic signed [PW-1:0] s2_p   [LANES];
  logic signed [ZW-1:0] s2_z   [LANES];
  logic [LANES-1:0]     s2_sat;

  logic signed [ZW-1:0] f_c    [LANES];
  logic signed [ZW-1:0] s3_f   [LANES];
  logic                 s3_any;

  logic signed [ZW-1:0] y_c    [LANES];
  logic [LANES*YW-1:0]  out_c;
  logic                 s4_any;

  // One enable for the whole pipe: it only moves when the output slot is free or draining.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: halve for sigmoid, take magnitude one bit wider so the most negative x stays positive.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      x_lane[k] = in_x[k*XW +: XW];
      z_c[k]    = in_mode ? ZW'(x_lane[k]) : ZW'(x_lane[k] >>> 1);
      a_c[k]    = z_c[k][ZW-1] ? -z_c[k] : z_c[k];
      sat_c[k]  = (a_c[k] >= SAT_LIM);
    end
  end

  // Stage 3: clamp to +-1.0 outside |z| < 2, otherwise subtract the floor-shifted quadratic term.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      f_c[k] = s2_sat[k] ? (s2_z[k][ZW-1] ? -ONE : ONE)
                         : ZW'(PW'(s2_z[k]) - (s2_p[k] >>> SH));
    end
  end

  // Stage 4: sigmoid is the tanh core remapped to (1 + f)/2, then both are scaled to the output format.
  always_comb begin
    out_c = '0;
    for (int k = 0; k < LANES; k++) begin
      y_c[k] = m3 ? s3_f[k] : HALF + (s3_f[k] >>> 1);
      out_c[k*YW +: YW] = YW'(y_c[k]) <<< OSH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples its
  // predecessor's pre-edge value; blocking here would collapse the pipeline into one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_y     <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      out_last  <= l3;
      out_y     <= out_c;
    end
  end

  // NOTE: the interior datapath is deliberately left without reset; the stage valids already
  // mark it meaningless after reset, and skipping the reset keeps the wide registers cheap.
  always_ff @(posedge clk) begin
    if (adv) begin
      m1     <= in_mode;
      l1     <= in_last;
      s1_sat <= sat_c;
      m2     <= m1;
      l2     <= l1;
      s2_sat <= s1_sat;
      m3     <= m2;
      l3     <= l2;
      s3_any <= |s2_sat;
      s4_any <= s3_any;
      for (int k = 0; k < LANES; k++) begin
        s1_z[k] <= z_c[k];
        s1_a[k] <= a_c[k];
        s2_p[k] <= PW'(s1_z[k]) * PW'(s1_a[k]);
        s2_z[k] <= s1_z[k];
        s3_f[k] <= f_c[k];
      end
    end
  end

  // Clear beats a simultaneous increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && s4_any && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_sigmoid_stream_pwq.sv
// Self-checking bench for sigmoid_stream_pwq: directed and random beats scored against an arithmetic model.
// A narrow saturation counter is used so the counter-ceiling case stays short.
module tb_sigmoid_stream_pwq;

  localparam int LANES = 16;
  localparam int XW    = 18;
  localparam int XFRAC = 14;
  localparam int YW    = 18;
  localparam int YFRAC = 16;
  localparam int CNTW  = 10;
  localparam int ONE   = 1 << XFRAC;
  localparam int VW    = LANES * YW;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic                in_mode;
  logic                in_last;
  logic [LANES*XW-1:0] in_x;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [LANES*YW-1:0] out_y;
  logic                cnt_clr;
  logic [CNTW-1:0]     sat_cnt;

  always #5 clk = ~clk;

  sigmoid_stream_pwq #(
    .LANES(LANES), .XW(XW), .XFRAC(XFRAC), .YW(YW), .YFRAC(YFRAC), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_last(in_last), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_y(out_y),
    .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
  );

  typedef struct {
    logic [VW-1:0] y;
    logic          last;
    logic          sat;
  } beat_t;

  beat_t         sb[$];
  int            checks   = 0;
  int            failures = 0;
  logic [CNTW-1:0] exp_cnt;
  logic [CNTW-1:0] cnt_max;
  logic          held;
  logic [VW-1:0] held_y;
  logic          held_last;
  bit            in_xfer;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the activation rules written as plain integer arithmetic on each lane.
  function automatic void ref_beat(input logic [LANES*XW-1:0] xv, input logic mode,
                                   output logic [VW-1:0] yv_o, output logic sat);
    longint x, z, a, f, y;
    yv_o = '0;
    sat  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      x = longint'($signed(xv[k*XW +: XW]));
      z = mode ? x : (x >>> 1);
      a = (z < 0) ? -z : z;
      if (a >= 2 * ONE) begin
        f   = (z < 0) ? -ONE : ONE;
        sat = 1'b1;
      end else begin
        f = z - ((z * a) >>> (XFRAC + 2));
      end
      y = mode ? f : (ONE / 2 + (f >>> 1));
      y = y * (1 << (YFRAC - XFRAC));
      yv_o[k*YW +: YW] = YW'(y);
    end
  endfunction

  function automatic logic [LANES*XW-1:0] mk4(input int a, input int b, input int c, input int d);
    int t[4];
    logic [LANES*XW-1:0] r;
    t = '{a, b, c, d};
    for (int k = 0; k < LANES; k++) r[k*XW +: XW] = XW'(t[k % 4]);
    return r;
  endfunction

  function automatic logic [YW-1:0] lane(input logic [VW-1:0] v, input int k);
    return v[k*YW +: YW];
  endfunction

  function automatic logic [YW-1:0] yv(input int v);
    return YW'(v);
  endfunction

  task automatic rand_beat();
    for (int k = 0; k < LANES; k++) in_x[k*XW +: XW] = XW'($urandom);
    in_mode = 1'($urandom % 2);
    in_last = 1'($urandom % 2);
  endtask

  // One clock of scoreboarding: record accepted beats, score delivered ones, watch stalls.
  task automatic tick();
    beat_t b;
    #1;
    in_xfer = in_valid && in_ready;
    if (in_xfer) begin
      ref_beat(in_x, in_mode, b.y, b.sat);
      b.last = in_last;
      sb.push_back(b);
    end
    if (held && out_valid) begin
      check("stable_y", out_y, held_y);
      check("stable_last", out_last, held_last);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", out_valid, 0);
      end else begin
        b = sb.pop_front();
        check("out_y", out_y, b.y);
        check("out_last", out_last, b.last);
        if (!cnt_clr && b.sat && exp_cnt != '1) exp_cnt++;
      end
    end
    if (cnt_clr) exp_cnt = '0;
    held      = out_valid && !out_ready;
    held_y    = out_y;
    held_last = out_last;
    @(posedge clk);
    #1;
  endtask

  // Counts cycles after an input transfer until out_valid shows; 9 means it never came.
  task automatic wait_out(output int n);
    n = 9;
    for (int i = 1; i <= 8; i++) begin
      #1;
      if (out_valid) begin
        n = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag, input bit rnd);
    in_valid = 1'b0;
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      tick();
    end
    out_ready = 1'b1;
    check(tag, sb.size(), 0);
  endtask

  initial begin
    int            lat;
    int            sent;
    logic [VW-1:0] got;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_last   = 1'b0;
    in_x      = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    exp_cnt   = '0;
    cnt_max   = '1;
    held      = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_y", out_y, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Single sigmoid beat: latency, spec values, counter
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_last   = 1'b1;
    in_x      = mk4(0, 16384, 49152, -131072);
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check("sig_latency", lat, 4);
    got = out_y;
    check("sig_x0", lane(got, 0), yv(32768));
    check("sig_x1p0", lane(got, 1), yv(47104));
    check("sig_x3p0", lane(got, 2), yv(63488));
    check("sig_xm8p0", lane(got, 3), yv(0));
    check("sig_last", out_last, 1);
    tick();
    check("sig_sat_cnt", sat_cnt, 1);
    check("sig_sat_model", sat_cnt, exp_cnt);

    // Single tanh beat
    in_valid = 1'b1;
    in_mode  = 1'b1;
    in_last  = 1'b0;
    in_x     = mk4(16384, -16384, 32768, 0);
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check("tanh_latency", lat, 4);
    got = out_y;
    check("tanh_x1p0", lane(got, 0), yv(49152));
    check("tanh_xm1p0", lane(got, 1), yv(-49152));
    check("tanh_x2p0", lane(got, 2), yv(65536));
    check("tanh_x0", lane(got, 3), yv(0));
    tick();
    check("tanh_sat_cnt", sat_cnt, 2);

    // Back-to-back random beats under random backpressure
    sent     = 0;
    in_valid = 1'b1;
    rand_beat();
    for (int c = 0; c < 2000 && sent < 64; c++) begin
      out_ready = 1'($urandom % 2);
      tick();
      if (in_xfer) begin
        sent++;
        rand_beat();
      end
    end
    check("stream_sent", sent, 64);
    drain("stream_drain", 1'b1);
    check("stream_sat_cnt", sat_cnt, exp_cnt);

    // Every input code in both modes, mode alternating per beat
    sent      = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 40000 && sent < 32768; c++) begin
      in_mode = sent[0];
      in_last = sent[5];
      for (int k = 0; k < LANES; k++) in_x[k*XW +: XW] = XW'((sent >> 1) * LANES + k);
      tick();
      if (in_xfer) sent++;
    end
    check("exh_sent", sent, 32768);
    drain("exh_drain", 1'b0);
    check("exh_sat_cnt", sat_cnt, exp_cnt);

    // Counter clear, climb to the ceiling, hold there
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_sat_cnt", sat_cnt, 0);
    sent     = 0;
    in_valid = 1'b1;
    in_x     = mk4(-131072, 0, 0, 0);
    for (int c = 0; c < 3000 && sent < (1 << CNTW) + 4; c++) begin
      in_mode = 1'($urandom % 2);
      tick();
      if (in_xfer) sent++;
    end
    drain("ceil_drain", 1'b0);
    check("ceil_sat_cnt", sat_cnt, cnt_max);
    check("ceil_sat_model", sat_cnt, exp_cnt);

    // Clear coinciding with a saturating output transfer
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check("clr_race_latency", lat, 4);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_race_sat_cnt", sat_cnt, 0);
    check("clr_race_model", sat_cnt, exp_cnt);

    // Reset with three beats in flight; build a nonzero count first
    in_valid = 1'b1;
    in_x     = mk4(-131072, 16384, 0, 0);
    tick();
    in_valid = 1'b0;
    drain("pre_rst_drain", 1'b0);
    check("pre_rst_sat_cnt", sat_cnt, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sat_cnt", sat_cnt, 0);
    check("midrst_out_y", out_y, 0);
    rst = 1'b0;
    sb.delete();
    exp_cnt = '0;
    held    = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_quiet", out_valid, 0);
    check("post_rst_sat_cnt", sat_cnt, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
